// File: rtl/hdmi_if_pkg.sv
// rtl/hdmi_if_pkg.sv - shared types for the HDMI raster/block path
//
// Purpose: common pixel type, block geometry and read-FSM state encoding
// used by raster_to_blocks and its stripe RAM.
package hdmi_if_pkg;

  localparam int BLK_DIM = 8;

  typedef logic signed [7:0] pix_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_t;

  // Bits in one stored beat: y, cb and cr planes of n pixels each.
  function automatic int ycc_beat_width(input int n);
    return 3 * n * $bits(pix_t);
  endfunction

endpackage

// File: rtl/stripe_ram.sv
// rtl/stripe_ram.sv - simple dual-port RAM holding both stripe banks
//
// Purpose: one write port, one read port with a registered (1-cycle) read.
// The address MSB selects the bank; the lower bits are row*BPL + col.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data (one packed y/cb/cr beat)
//   raddr - read address, sampled every cycle
//   rdata - read data, valid one cycle after raddr
module stripe_ram #(
  parameter int AW = 7,
  parameter int DW = 48
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/raster_to_blocks.sv
// rtl/raster_to_blocks.sv - raster YCbCr stream to 8x8 block stream converter
//
// Purpose: gathers 8 raster lines into one of two ping-pong stripe banks,
// then replays each full stripe as 8x8 blocks in block-row-major order with
// sob/eob/sof framing. No backpressure on either side.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   in_valid, in_sof, in_eol        - raster beat qualifiers
//   in_data_y/cb/cr                 - N pixels per beat, pixel 0 leftmost
//   out_valid, out_sob/eob/sof      - block beat qualifiers and framing
//   out_data_y/cb/cr                - N block pixels per beat
//   overflow                        - sticky: write hit a full bank
//   line_err                        - sticky: in_eol position wrong
module raster_to_blocks
  import hdmi_if_pkg::*;
#(
  parameter int N     = 2,
  parameter int X_RES = 2160
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [N-1:0][7:0] in_data_y,
  input  logic signed [N-1:0][7:0] in_data_cb,
  input  logic signed [N-1:0][7:0] in_data_cr,
  input  logic                    in_sof,
  input  logic                    in_eol,
  output logic                    out_valid,
  output logic signed [N-1:0][7:0] out_data_y,
  output logic signed [N-1:0][7:0] out_data_cb,
  output logic signed [N-1:0][7:0] out_data_cr,
  output logic                    out_sob,
  output logic                    out_eob,
  output logic                    out_sof,
  output logic                    overflow,
  output logic                    line_err
);

  localparam int BPL  = X_RES / N;
  localparam int BPR  = BLK_DIM / N;
  localparam int NBLK = X_RES / BLK_DIM;
  localparam int DW   = ycc_beat_width(N);
  localparam int BAW  = $clog2(BLK_DIM * BPL);
  localparam int AW   = BAW + 1;
  localparam int CW   = $clog2(BPL + 1);
  localparam int KW   = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  localparam logic [KW-1:0] KMAX = KW'(BPR - 1);
  localparam logic [BW-1:0] BMAX = BW'(NBLK - 1);

  typedef struct packed {
    pix_t [N-1:0] y;
    pix_t [N-1:0] cb;
    pix_t [N-1:0] cr;
  } ycc_beat_t;

  // Write side state
  logic [CW-1:0]  col;
  logic [2:0]     row;
  logic           wbank;

  // Shared bank status
  logic [1:0]     bank_full;
  logic [1:0]     sof_tag;

  // Read side state
  rd_state_t      state;
  logic           rbank;
  logic [BW-1:0]  rd_b;
  logic [2:0]     rd_r;
  logic [KW-1:0]  rd_k;

  // Pipeline stage aligned with RAM read data
  logic           v1, sob1, eob1, sof1;
  ycc_beat_t      out_q;

  // Write-side decode
  logic [CW-1:0]  eff_col;
  logic [2:0]     eff_row;
  logic           eff_bank;
  logic           in_range;
  logic           wr_en;
  logic [BAW-1:0] wr_off;
  logic [1:0]     bf_set;
  logic           sof_set;

  // Read-side decode
  logic           rd_go;
  logic           rd_first;
  logic           rd_last;
  logic [BAW-1:0] rd_off;
  logic [1:0]     bf_clr;
  logic [1:0]     tag_clr;

  ycc_beat_t      wr_beat;
  ycc_beat_t      rd_beat;
  logic [DW-1:0]  rd_data;

  assign wr_beat = '{y: in_data_y, cb: in_data_cb, cr: in_data_cr};
  assign rd_beat = rd_data;

  // in_sof restarts the stripe in bank 0 before this beat is placed.
  always_comb begin
    eff_col  = in_sof ? '0 : col;
    eff_row  = in_sof ? 3'd0 : row;
    eff_bank = in_sof ? 1'b0 : wbank;
    in_range = eff_col < CW'(BPL);
    wr_en    = in_valid && in_range && !bank_full[eff_bank];
    wr_off   = BAW'(eff_row) * BAW'(BPL) + BAW'(eff_col);
    sof_set  = in_valid && in_sof;
    bf_set   = '0;
    if (in_valid && in_eol && eff_row == 3'd7) bf_set[eff_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      wbank    <= 1'b0;
      overflow <= 1'b0;
      line_err <= 1'b0;
    end else if (in_valid) begin
      if (!in_range) line_err <= 1'b1;
      if (in_range && bank_full[eff_bank]) overflow <= 1'b1;
      if (in_eol) begin
        if (eff_col != CW'(BPL - 1)) line_err <= 1'b1;
        col   <= '0;
        row   <= eff_row + 3'd1;
        wbank <= (eff_row == 3'd7) ? ~eff_bank : eff_bank;
      end else begin
        // Out-of-range beats hold col at BPL until the line ends.
        col   <= in_range ? eff_col + CW'(1) : eff_col;
        row   <= eff_row;
        wbank <= eff_bank;
      end
    end
  end

  // The first address of a stripe is issued combinationally from IDLE so the
  // first block beat appears two edges after the bank fills.
  always_comb begin
    rd_go    = (state == RUN) || (state == IDLE && bank_full[rbank]);
    rd_first = (rd_b == '0) && (rd_r == 3'd0) && (rd_k == '0);
    rd_last  = (rd_b == BMAX) && (rd_r == 3'd7) && (rd_k == KMAX);
    rd_off   = BAW'(rd_r) * BAW'(BPL) + BAW'(rd_b) * BAW'(BPR) + BAW'(rd_k);
    bf_clr   = '0;
    tag_clr  = '0;
    if (rd_go && rd_last)  bf_clr[rbank]  = 1'b1;
    if (rd_go && rd_first) tag_clr[rbank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rbank       <= 1'b0;
      rd_b        <= '0;
      rd_r        <= '0;
      rd_k        <= '0;
      bank_full   <= '0;
      sof_tag     <= '0;
      v1          <= 1'b0;
      sob1        <= 1'b0;
      eob1        <= 1'b0;
      sof1        <= 1'b0;
      out_valid   <= 1'b0;
      out_sob     <= 1'b0;
      out_eob     <= 1'b0;
      out_sof     <= 1'b0;
      out_q       <= '0;
    end else begin
      // Set wins so a writer event is never lost to a same-cycle clear.
      bank_full <= (bank_full & ~bf_clr) | bf_set;
      sof_tag   <= (sof_tag & ~tag_clr) | {1'b0, sof_set};

      v1   <= rd_go;
      sob1 <= rd_go && rd_r == 3'd0 && rd_k == '0;
      eob1 <= rd_go && rd_r == 3'd7 && rd_k == KMAX;
      sof1 <= rd_go && rd_first && sof_tag[rbank];

      out_valid <= v1;
      out_sob   <= sob1;
      out_eob   <= eob1;
      out_sof   <= sof1;
      if (v1) out_q <= rd_beat;

      if (rd_go) begin
        if (rd_k == KMAX) begin
          rd_k <= '0;
          if (rd_r == 3'd7) begin
            rd_r <= 3'd0;
            rd_b <= (rd_b == BMAX) ? '0 : rd_b + BW'(1);
          end else begin
            rd_r <= rd_r + 3'd1;
          end
        end else begin
          rd_k <= rd_k + KW'(1);
        end
        if (rd_last) rbank <= ~rbank;
      end

      case (state)
        IDLE:    if (bank_full[rbank]) state <= RUN;
        RUN:     if (rd_last) state <= bank_full[~rbank] ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_data_y  = out_q.y;
  assign out_data_cb = out_q.cb;
  assign out_data_cr = out_q.cr;

  stripe_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({eff_bank, wr_off}),
    .wdata (wr_beat),
    .raddr ({rbank, rd_off}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_raster_to_blocks.sv
// tb/tb_raster_to_blocks.sv - directed self-checking bench for raster_to_blocks
module tb_raster_to_blocks;

  localparam int N      = 2;
  localparam int X_RES  = 16;
  localparam int BPL    = 8;
  localparam int BPR    = 4;
  localparam int BPB    = 32;
  localparam int SBEATS = 64;

  logic clk, rst_n, in_valid, in_sof, in_eol;
  logic signed [N-1:0][7:0] in_data_y, in_data_cb, in_data_cr;
  logic out_valid, out_sob, out_eob, out_sof, overflow, line_err;
  logic signed [N-1:0][7:0] out_data_y, out_data_cb, out_data_cr;

  raster_to_blocks #(.N(N), .X_RES(X_RES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data_y   (in_data_y),
    .in_data_cb  (in_data_cb),
    .in_data_cr  (in_data_cr),
    .in_sof      (in_sof),
    .in_eol      (in_eol),
    .out_valid   (out_valid),
    .out_data_y  (out_data_y),
    .out_data_cb (out_data_cb),
    .out_data_cr (out_data_cr),
    .out_sob     (out_sob),
    .out_eob     (out_eob),
    .out_sof     (out_sof),
    .overflow    (overflow),
    .line_err    (line_err)
  );

  typedef struct {
    logic [N-1:0][7:0] y, cb, cr;
    logic sob, eob, sof;
    int   cyc;
  } beat_t;

  typedef struct {
    int         idx;
    logic [7:0] y0, y1, cb0, cr0;
    logic       sob, eob, sof;
  } vec_t;

  beat_t cap[$];
  vec_t  tbl[7];
  int    cyc = 0;
  int    last_wr_cyc = 0;
  int    checks = 0;
  int    errors = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && out_valid)
      cap.push_back('{out_data_y, out_data_cb, out_data_cr, out_sob, out_eob, out_sof, cyc});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] pix(input int l, input int x, input int off);
    return 8'(l * 16 + x + off);
  endfunction

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int l, input int c, input logic sof, input logic eol);
    in_valid = 1'b1;
    in_sof   = sof;
    in_eol   = eol;
    for (int p = 0; p < N; p++) begin
      in_data_y[p]  = pix(l, c * N + p, 0);
      in_data_cb[p] = pix(l, c * N + p, 64);
      in_data_cr[p] = pix(l, c * N + p, 128);
    end
    @(posedge clk);
    #1;
    last_wr_cyc = cyc;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic send_line(input int l, input logic sof, input int len, input int gapmax);
    for (int c = 0; c < len; c++) begin
      drive(l, c, sof && c == 0, c == len - 1);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
  endtask

  task automatic send_lines(input int l0, input int cnt, input logic sof, input int gapmax);
    for (int l = 0; l < cnt; l++) send_line(l0 + l, sof && l == 0, BPL, gapmax);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    idle(2);
    rst_n = 1'b1;
    cap.delete();
    idle(1);
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int t;
    t = 0;
    while (cap.size() < n && t < budget) begin
      idle(1);
      t++;
    end
    checks++;
    if (cap.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d beats, want %0d", name, cap.size(), n);
    end
  endtask

  // Expected stripe: block-row-major 8x8 blocks of pixel value line*16+x.
  // Pixels on line skip_l at x >= skip_x are not compared.
  task automatic check_stripe(input string name, input int base, input int lbase,
                              input logic exp_sof, input int skip_l, input int skip_x);
    beat_t c;
    logic [N-1:0][7:0] ey, ecb, ecr;
    logic ok;
    int blk, r, k, x;
    for (int i = 0; i < SBEATS; i++) begin
      if (base + i >= cap.size()) break;
      c   = cap[base + i];
      blk = i / BPB;
      r   = (i % BPB) / BPR;
      k   = i % BPR;
      ok  = (c.sob == (i % BPB == 0)) && (c.eob == (i % BPB == BPB - 1)) &&
            (c.sof == (exp_sof && i == 0));
      for (int p = 0; p < N; p++) begin
        x      = blk * 8 + k * N + p;
        ey[p]  = pix(lbase + r, x, 0);
        ecb[p] = pix(lbase + r, x, 64);
        ecr[p] = pix(lbase + r, x, 128);
        if (!((lbase + r) == skip_l && x >= skip_x))
          ok = ok && c.y[p] == ey[p] && c.cb[p] == ecb[p] && c.cr[p] == ecr[p];
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s beat %0d: got y=%h cb=%h cr=%h sob=%b eob=%b sof=%b, want y=%h cb=%h cr=%h sob=%b eob=%b sof=%b",
                 name, i, c.y, c.cb, c.cr, c.sob, c.eob, c.sof, ey, ecb, ecr,
                 i % BPB == 0, i % BPB == BPB - 1, exp_sof && i == 0);
      end
    end
  endtask

  initial begin
    int sofs;
    beat_t c;

    // Hand-computed beats of the basic stripe: {index, y[0], y[1], cb[0], cr[0], sob, eob, sof}
    tbl[0] = '{0,  8'h00, 8'h01, 8'h40, 8'h80, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{3,  8'h06, 8'h07, 8'h46, 8'h86, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4,  8'h10, 8'h11, 8'h50, 8'h90, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{31, 8'h76, 8'h77, 8'hB6, 8'hF6, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32, 8'h08, 8'h09, 8'h48, 8'h88, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{45, 8'h3A, 8'h3B, 8'h7A, 8'hBA, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{63, 8'h7E, 8'h7F, 8'hBE, 8'hFE, 1'b0, 1'b1, 1'b0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    in_eol     = 1'b0;
    in_data_y  = '0;
    in_data_cb = '0;
    in_data_cr = '0;
    #2;
    check_val("reset out_valid", int'(out_valid), 0);
    check_val("reset out_sob", int'(out_sob), 0);
    check_val("reset out_eob", int'(out_eob), 0);
    check_val("reset out_sof", int'(out_sof), 0);
    check_val("reset overflow", int'(overflow), 0);
    check_val("reset line_err", int'(line_err), 0);
    check_val("reset out_data", int'({out_data_y, out_data_cb, out_data_cr} != 0), 0);

    // Basic stripe
    do_reset();
    send_lines(0, 8, 1'b1, 0);
    wait_beats("basic", SBEATS, 200);
    if (cap.size() > 0) check_val("basic first latency", cap[0].cyc - last_wr_cyc, 2);
    idle(20);
    check_val("basic beat count", cap.size(), SBEATS);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].idx < cap.size()) begin
        c = cap[tbl[i].idx];
        checks++;
        if (c.y[0] != tbl[i].y0 || c.y[1] != tbl[i].y1 || c.cb[0] != tbl[i].cb0 ||
            c.cr[0] != tbl[i].cr0 || c.sob != tbl[i].sob || c.eob != tbl[i].eob ||
            c.sof != tbl[i].sof) begin
          errors++;
          $display("FAIL table beat %0d: got y=%h,%h cb=%h cr=%h sob=%b eob=%b sof=%b, want y=%h,%h cb=%h cr=%h sob=%b eob=%b sof=%b",
                   tbl[i].idx, c.y[0], c.y[1], c.cb[0], c.cr[0], c.sob, c.eob, c.sof,
                   tbl[i].y0, tbl[i].y1, tbl[i].cb0, tbl[i].cr0, tbl[i].sob, tbl[i].eob, tbl[i].sof);
        end
      end
    end
    check_stripe("basic", 0, 0, 1'b1, -1, 0);
    check_val("basic overflow", int'(overflow), 0);
    check_val("basic line_err", int'(line_err), 0);

    // Back-to-back stripes
    do_reset();
    send_lines(0, 16, 1'b1, 0);
    wait_beats("b2b", 2 * SBEATS, 300);
    idle(20);
    check_val("b2b beat count", cap.size(), 2 * SBEATS);
    if (cap.size() >= 2 * SBEATS)
      check_val("b2b contiguous span", cap[2 * SBEATS - 1].cyc - cap[0].cyc, 2 * SBEATS - 1);
    sofs = 0;
    foreach (cap[i]) sofs += int'(cap[i].sof);
    check_val("b2b sof count", sofs, 1);
    check_stripe("b2b s0", 0, 0, 1'b1, -1, 0);
    check_stripe("b2b s1", SBEATS, 8, 1'b0, -1, 0);
    check_val("b2b overflow", int'(overflow), 0);

    // Random input gaps
    do_reset();
    send_lines(0, 8, 1'b1, 10);
    wait_beats("gaps", SBEATS, 2000);
    idle(20);
    check_val("gaps beat count", cap.size(), SBEATS);
    check_stripe("gaps", 0, 0, 1'b1, -1, 0);
    check_val("gaps overflow", int'(overflow), 0);

    // Short line 3 ends at col 5
    do_reset();
    send_lines(0, 3, 1'b1, 0);
    check_val("short line_err before", int'(line_err), 0);
    send_line(3, 1'b0, 6, 0);
    check_val("short line_err after", int'(line_err), 1);
    send_lines(4, 4, 1'b0, 0);
    wait_beats("short", SBEATS, 200);
    idle(20);
    check_val("short beat count", cap.size(), SBEATS);
    check_stripe("short", 0, 0, 1'b1, 3, 12);

    // in_sof together with in_eol is a one-beat line
    do_reset();
    drive(0, 0, 1'b1, 1'b1);
    check_val("sof+eol line_err", int'(line_err), 1);
    check_val("sof+eol overflow", int'(overflow), 0);

    // Mid-stripe restart after 4 lines
    do_reset();
    send_lines(8, 4, 1'b1, 0);
    send_lines(0, 8, 1'b1, 0);
    wait_beats("restart", SBEATS, 200);
    idle(30);
    check_val("restart beat count", cap.size(), SBEATS);
    check_stripe("restart", 0, 0, 1'b1, -1, 0);
    check_val("restart overflow", int'(overflow), 0);
    check_val("restart line_err", int'(line_err), 0);

    // Overflow: in_sof reuses bank 0 while it is being read
    do_reset();
    send_lines(0, 8, 1'b1, 0);
    check_val("ovf before restart", int'(overflow), 0);
    send_lines(8, 8, 1'b1, 0);
    check_val("ovf after restart", int'(overflow), 1);
    wait_beats("ovf", SBEATS, 200);
    check_stripe("ovf bank0", 0, 0, 1'b1, -1, 0);
    check_val("ovf line_err", int'(line_err), 0);

    // Asynchronous reset while streaming stops the output at once
    do_reset();
    send_lines(0, 8, 1'b1, 0);
    wait_beats("async", 10, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async reset out_valid", int'(out_valid), 0);
    check_val("async reset out_data", int'({out_data_y, out_data_cb, out_data_cr} != 0), 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
